pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 132 +++++++++++++
 tb/tb_pll_reset_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// Reset sequencer for the 80 MHz PLL domain: waits for a stable lock, releases
// the core reset and then the peripheral reset, and generates divided clock enables.
module pll_reset_seq #(
  parameter int LOCK_STABLE = 1024,
  parameter int RELEASE_GAP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sw_reset,
  input  logic       lost_clr,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       ce_40,
  output logic       ce_10,
  output logic       running,
  output logic       lock_lost,
  output logic [7:0] relock_cnt
);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, REL_CORE, RUN} state_t;

  localparam logic [15:0] STAB_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(RELEASE_GAP - 1);

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] stab_cnt_q, stab_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [2:0]  div_cnt_q, div_cnt_d;
  logic        lock_lost_q, lock_lost_d;
  logic [7:0]  relock_cnt_q, relock_cnt_d;
  logic        rst_core_q, rst_core_d;
  logic        rst_periph_q, rst_periph_d;
  logic        running_q, running_d;
  logic        ce_40_q, ce_40_d;
  logic        ce_10_q, ce_10_d;
  logic        locked_s;
  logic        run_loss;

  assign locked_s = sync_q[1];

  always_comb begin
    sync_d     = {sync_q[0], pll_locked};
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    run_loss   = 1'b0;

    // Lock loss outranks sw_reset, so only a genuine loss from RUN is counted.
    if (state_q == WAIT_LOCK) begin
      if (locked_s) begin
        state_d    = STABLE;
        stab_cnt_d = '0;
      end
    end else if (!locked_s) begin
      state_d  = WAIT_LOCK;
      run_loss = (state_q == RUN);
    end else if (sw_reset) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        STABLE: begin
          if (stab_cnt_q == STAB_LAST) begin
            state_d   = REL_CORE;
            gap_cnt_d = '0;
          end else begin
            stab_cnt_d = stab_cnt_q + 16'd1;
          end
        end
        REL_CORE: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = RUN;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    div_cnt_d    = (state_q == RUN && state_d == RUN) ? div_cnt_q + 3'd1 : 3'd0;
    lock_lost_d  = run_loss ? 1'b1 : (lost_clr ? 1'b0 : lock_lost_q);
    relock_cnt_d = (run_loss && relock_cnt_q != 8'hFF) ? relock_cnt_q + 8'd1 : relock_cnt_q;

    // Outputs are registered from the next state so they line up with state_q.
    rst_core_d   = (state_d == WAIT_LOCK) || (state_d == STABLE);
    rst_periph_d = (state_d != RUN);
    running_d    = (state_d == RUN);
    ce_40_d      = running_d && !div_cnt_d[0];
    ce_10_d      = running_d && (div_cnt_d == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      sync_q       <= '0;
      stab_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      div_cnt_q    <= '0;
      lock_lost_q  <= 1'b0;
      relock_cnt_q <= '0;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      running_q    <= 1'b0;
      ce_40_q      <= 1'b0;
      ce_10_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      stab_cnt_q   <= stab_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      div_cnt_q    <= div_cnt_d;
      lock_lost_q  <= lock_lost_d;
      relock_cnt_q <= relock_cnt_d;
      rst_core_q   <= rst_core_d;
      rst_periph_q <= rst_periph_d;
      running_q    <= running_d;
      ce_40_q      <= ce_40_d;
      ce_10_q      <= ce_10_d;
    end
  end

  assign rst_core   = rst_core_q;
  assign rst_periph = rst_periph_q;
  assign running    = running_q;
  assign ce_40      = ce_40_q;
  assign ce_10      = ce_10_q;
  assign lock_lost  = lock_lost_q;
  assign relock_cnt = relock_cnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed timing checks plus randomized traffic compared
// every cycle against a progress-counter model of the reset sequence.
module tb_pll_reset_seq;

  localparam int LS = 8;
  localparam int RG = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sw_reset;
  logic       lost_clr;
  logic       rst_core;
  logic       rst_periph;
  logic       ce_40;
  logic       ce_10;
  logic       running;
  logic       lock_lost;
  logic [7:0] relock_cnt;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 1'b0;

  // Model: m_t is cycles since the sequence entered the lock-stable phase, -1 while waiting.
  logic [1:0] m_sync = 2'b00;
  int         m_t = -1;
  bit         m_lost = 1'b0;
  int         m_cnt = 0;
  logic       m_loss;

  pll_reset_seq #(.LOCK_STABLE(LS), .RELEASE_GAP(RG)) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .sw_reset(sw_reset),
    .lost_clr(lost_clr),
    .rst_core(rst_core),
    .rst_periph(rst_periph),
    .ce_40(ce_40),
    .ce_10(ce_10),
    .running(running),
    .lock_lost(lock_lost),
    .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  assign m_loss = (m_t >= LS + RG) && !m_sync[1];

  always @(posedge clk) begin
    if (rst) begin
      m_sync <= 2'b00;
      m_t    <= -1;
      m_lost <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_sync <= {m_sync[0], pll_locked};
      if (m_t >= 0 && (!m_sync[1] || sw_reset)) m_t <= -1;
      else if (m_t >= 0) m_t <= m_t + 1;
      else if (m_sync[1]) m_t <= 0;
      m_lost <= m_loss ? 1'b1 : (lost_clr ? 1'b0 : m_lost);
      m_cnt  <= (m_loss && m_cnt < 255) ? m_cnt + 1 : m_cnt;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit locked, input bit sw, input bit clr, input bit r);
    @(negedge clk);
    pll_locked = locked;
    sw_reset   = sw;
    lost_clr   = clr;
    rst        = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitRunning();
    int n = 0;
    while (!running && n < 200) begin
      step();
      n++;
    end
    checkOutput("wait_running", int'(running), 1);
  endtask

  always @(negedge clk) begin
    bit e_run;
    int k;
    if (cmp_en) begin
      e_run = (m_t >= LS + RG);
      k     = m_t - LS - RG;
      checkOutput("cmp_rst_core", int'(rst_core), int'(m_t < LS));
      checkOutput("cmp_rst_periph", int'(rst_periph), int'(m_t < LS + RG));
      checkOutput("cmp_running", int'(running), int'(e_run));
      checkOutput("cmp_ce_40", int'(ce_40), int'(e_run && (k % 2 == 0)));
      checkOutput("cmp_ce_10", int'(ce_10), int'(e_run && (k % 8 == 0)));
      checkOutput("cmp_lock_lost", int'(lock_lost), int'(m_lost));
      checkOutput("cmp_relock_cnt", int'(relock_cnt), m_cnt);
    end
  end

  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int n40;
    int n10;
    int n;

    pll_locked = 1'b0;
    sw_reset   = 1'b0;
    lost_clr   = 1'b0;
    rst        = 1'b1;
    repeat (3) step();
    cmp_en = 1'b1;
    $display("[TB] reset state");
    checkOutput("reset_rst_core", int'(rst_core), 1);
    checkOutput("reset_rst_periph", int'(rst_periph), 1);
    checkOutput("reset_running", int'(running), 0);
    checkOutput("reset_ce_40", int'(ce_40), 0);
    checkOutput("reset_ce_10", int'(ce_10), 0);
    checkOutput("reset_relock_cnt", int'(relock_cnt), 0);
    checkOutput("reset_lock_lost", int'(lock_lost), 0);

    // Lock rises before edge 1: core released after edge 11, periph/run after edge 15.
    applyStimulus(1, 0, 0, 0);
    for (int e = 1; e <= 15; e++) begin
      step();
      if (e == 10) checkOutput("seq_core_e10", int'(rst_core), 1);
      if (e == 11) begin
        checkOutput("seq_core_e11", int'(rst_core), 0);
        checkOutput("seq_periph_e11", int'(rst_periph), 1);
      end
      if (e == 14) checkOutput("seq_running_e14", int'(running), 0);
      if (e == 15) begin
        checkOutput("seq_running_e15", int'(running), 1);
        checkOutput("seq_periph_e15", int'(rst_periph), 0);
        checkOutput("seq_ce40_first", int'(ce_40), 1);
        checkOutput("seq_ce10_first", int'(ce_10), 1);
      end
    end

    n40 = 0;
    n10 = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < 4) checkOutput("ce40_pattern", int'(ce_40), int'(pat[i]));
      n40 += int'(ce_40);
      n10 += int'(ce_10);
      step();
    end
    checkOutput("ce40_pulses", n40, 16);
    checkOutput("ce10_pulses", n10, 4);

    $display("[TB] lock loss in RUN");
    applyStimulus(0, 0, 0, 0);
    step();
    checkOutput("loss_core_n", int'(rst_core), 0);
    applyStimulus(1, 0, 0, 0);
    step();
    checkOutput("loss_core_n1", int'(rst_core), 0);
    step();
    checkOutput("loss_core_n2", int'(rst_core), 1);
    checkOutput("loss_periph_n2", int'(rst_periph), 1);
    checkOutput("loss_lost_n2", int'(lock_lost), 1);
    checkOutput("loss_cnt_n2", int'(relock_cnt), 1);
    repeat (8) step();
    checkOutput("relock_core_held", int'(rst_core), 1);
    step();
    checkOutput("relock_core_rel", int'(rst_core), 0);
    repeat (3) step();
    checkOutput("relock_not_running", int'(running), 0);
    step();
    checkOutput("relock_running", int'(running), 1);

    $display("[TB] glitch in STABLE");
    applyStimulus(1, 0, 0, 1);
    step();
    applyStimulus(1, 0, 0, 0);
    repeat (6) step();
    applyStimulus(0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0);
    step();
    step();
    checkOutput("glitch_cnt", int'(relock_cnt), 0);
    checkOutput("glitch_lost", int'(lock_lost), 0);
    repeat (8) step();
    checkOutput("glitch_core_e17", int'(rst_core), 1);
    step();
    checkOutput("glitch_core_e18", int'(rst_core), 0);

    $display("[TB] sw_reset and lost_clr");
    waitRunning();
    applyStimulus(1, 1, 0, 0);
    step();
    checkOutput("sw_core", int'(rst_core), 1);
    checkOutput("sw_periph", int'(rst_periph), 1);
    checkOutput("sw_running", int'(running), 0);
    checkOutput("sw_cnt", int'(relock_cnt), 0);
    applyStimulus(1, 0, 0, 0);
    waitRunning();
    applyStimulus(0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0);
    step();
    applyStimulus(1, 0, 1, 0);
    step();
    checkOutput("setclr_lost", int'(lock_lost), 1);
    checkOutput("setclr_cnt", int'(relock_cnt), 1);
    step();
    checkOutput("clr_lost", int'(lock_lost), 0);
    applyStimulus(1, 0, 0, 0);

    $display("[TB] relock saturation");
    for (int i = 0; i < 256; i++) begin
      waitRunning();
      applyStimulus(0, 0, 0, 0);
      step();
      applyStimulus(1, 0, 0, 0);
      step();
      step();
      if (i == 252) checkOutput("sat_cnt_254", int'(relock_cnt), 254);
    end
    checkOutput("sat_cnt_255", int'(relock_cnt), 255);

    $display("[TB] rst in REL_CORE");
    n = 0;
    while (!(rst_core == 1'b0 && rst_periph == 1'b1) && n < 200) begin
      step();
      n++;
    end
    checkOutput("wait_rel_core", int'(rst_core == 1'b0 && rst_periph == 1'b1), 1);
    applyStimulus(1, 0, 0, 1);
    step();
    checkOutput("rstrel_core", int'(rst_core), 1);
    checkOutput("rstrel_periph", int'(rst_periph), 1);
    checkOutput("rstrel_cnt", int'(relock_cnt), 0);
    checkOutput("rstrel_lost", int'(lock_lost), 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 97,
                    $urandom_range(0, 199) == 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 299) == 0);
    end
    applyStimulus(1, 0, 0, 0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
